mem_cmd_arbiter: RTL

Single-clock arbiter in the clk_mem domain that shares the memory controller's 2-bit command channel between a row writer (pattern generator / camera path) and a row reader (display path). It grants one requester at a time, issues that requester's command, and holds the grant for the whole row burst. During the burst it drives the row-buffer word address, so the granted side's buffer is sequenced by this block.

---
 rtl/mem_cmd_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_arbiter.sv
// rtl/mem_cmd_arbiter.sv - round-robin arbiter sharing the memory command channel between row writer and row reader (optional watchdog: ARB_TIMEOUT_EN)
module mem_cmd_arbiter #(
  parameter int ROW_WORDS      = 320,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_mem,
  input  logic                  reset_n,
  input  logic                  wr_req_valid,
  input  logic [1:0]            wr_req_cmd,
  output logic                  wr_req_ready,
  input  logic                  rd_req_valid,
  input  logic [1:0]            rd_req_cmd,
  output logic                  rd_req_ready,
  output logic [1:0]            command_data,
  output logic                  command_data_valid,
  input  logic                  mem_controller_rdy,
  input  logic                  mem_word_strobe,
  input  logic                  mem_xfer_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  grant_wr,
  output logic                  grant_rd,
  output logic                  arb_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_FRAME = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_WORDS - 1);

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic                  grant_wr_q, grant_wr_d;
  logic                  grant_rd_q, grant_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  // 1 = writer held the channel last, 0 = reader (reset value, so writer wins first tie)
  logic                  last_wr_q, last_wr_d;

  logic                  sel_wr;
  logic                  sel_rd;
  logic                  idle;

`ifdef ARB_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]             cnt_q, cnt_d;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  assign idle = (state_q == S_IDLE);

  // Round-robin pick: on a tie the side that did not own the channel last wins
  always_comb begin
    sel_wr = wr_req_valid && (!rd_req_valid || !last_wr_q);
    sel_rd = rd_req_valid && !sel_wr;
  end

  // Accept handshake is combinational and only offered while idle and out of reset
  always_comb begin
    wr_req_ready = reset_n && idle && sel_wr;
    rd_req_ready = reset_n && idle && sel_rd;
  end

  // Next-state logic: accept, issue, burst sequencing and error tracking
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    grant_wr_d = grant_wr_q;
    grant_rd_d = grant_rd_q;
    addr_d     = addr_q;
    err_d      = err_q;
    last_wr_d  = last_wr_q;

    case (state_q)
      S_IDLE: begin
        if (sel_wr) begin
          cmd_d = wr_req_cmd;
          if ((wr_req_cmd == CMD_FRAME) || (wr_req_cmd == CMD_WRITE)) begin
            grant_wr_d = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            // Bad command is swallowed; rotate priority so it cannot starve the reader
            err_d     = 1'b1;
            last_wr_d = 1'b1;
          end
        end else if (sel_rd) begin
          cmd_d = rd_req_cmd;
          if ((rd_req_cmd == CMD_FRAME) || (rd_req_cmd == CMD_READ)) begin
            grant_rd_d = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            err_d     = 1'b1;
            last_wr_d = 1'b0;
          end
        end
      end

      S_ISSUE: begin
        if (mem_controller_rdy) begin
          if (cmd_q == CMD_FRAME) begin
            // Frame start has no data phase: release the channel immediately
            state_d    = S_IDLE;
            last_wr_d  = grant_wr_q;
            grant_wr_d = 1'b0;
            grant_rd_d = 1'b0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (mem_xfer_done) begin
          // Done takes priority over a coincident strobe
          state_d    = S_IDLE;
          addr_d     = '0;
          last_wr_d  = grant_wr_q;
          grant_wr_d = 1'b0;
          grant_rd_d = 1'b0;
        end else if (mem_word_strobe) begin
          if (addr_q == LAST_ADDR) begin
            // Controller moved more words than a row holds
            addr_d = '0;
            err_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        grant_wr_d = 1'b0;
        grant_rd_d = 1'b0;
        addr_d     = '0;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort on the last allowed cycle in ISSUE or BUSY
    if ((state_q != S_IDLE) && (cnt_q == TO_LAST)) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      addr_d     = '0;
      last_wr_d  = grant_wr_q;
      grant_wr_d = 1'b0;
      grant_rd_d = 1'b0;
    end
`endif
  end

`ifdef ARB_TIMEOUT_EN
  // Cycles spent in the current non-idle state; restarts on every transition
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q != S_IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 2'd0;
      grant_wr_q <= 1'b0;
      grant_rd_q <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      last_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      grant_wr_q <= grant_wr_d;
      grant_rd_q <= grant_rd_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      last_wr_q  <= last_wr_d;
    end
  end

  // Command is presented for as long as the FSM sits in ISSUE
  always_comb begin
    command_data_valid = (state_q == S_ISSUE);
    command_data       = (state_q == S_ISSUE) ? cmd_q : 2'd0;
  end

  assign mem_addr  = addr_q;
  assign grant_wr  = grant_wr_q;
  assign grant_rd  = grant_rd_q;
  assign arb_error = err_q;

endmodule
